// File: rtl/fifo_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_uart_pkg
//  Purpose  : Shared types and constants for the FIFO-fed UART transmitter.
//  Revision : 1.0 - initial release
// ============================================================================
package fifo_uart_pkg;

   localparam int DATA_W = 8;

   // 3-bit state encoding of the transmit sequencer
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_LOAD   = 3'd2;
   localparam logic [2:0] S_START  = 3'd3;
   localparam logic [2:0] S_DATA   = 3'd4;
   localparam logic [2:0] S_PARITY = 3'd5;
   localparam logic [2:0] S_STOP   = 3'd6;

   typedef enum logic [2:0] {
      ST_IDLE   = S_IDLE,
      ST_FETCH  = S_FETCH,
      ST_LOAD   = S_LOAD,
      ST_START  = S_START,
      ST_DATA   = S_DATA,
      ST_PARITY = S_PARITY,
      ST_STOP   = S_STOP
   } state_e;

   // Even parity: the bit that makes the total count of ones even
   function automatic logic even_parity(input logic [DATA_W-1:0] i_d);
      return ^i_d;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
//  Module   : uart_baud_tick
//  Purpose  : Bit-period counter. Counts 0..CLKS_PER_BIT-1 and flags the last
//             cycle of each bit; held at zero while clr is high.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_baud_tick #(
   parameter  int CLKS_PER_BIT = 16,
   localparam int CNT_W        = $clog2(CLKS_PER_BIT)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   output logic             tick,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] r_count;
   logic             w_last;

   assign w_last = (r_count == C_LAST);
   assign tick   = w_last & ~clr;
   assign count  = r_count;

   // Free-running bit-period counter, wrapping at each bit boundary
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
      end else if (clr || w_last) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_uart_tx
//  Purpose  : Drains bytes from a synchronous FIFO and sends each one as a
//             UART frame: start, 8 data bits LSB-first, optional even
//             parity, 1 or 2 stop bits. tx lags the sequencer state by one
//             cycle so that every line value comes straight from a flop.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_uart_tx
   import fifo_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_EN    = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tx_en,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_data,
   output logic              fifo_rd,
   output logic              tx,
   output logic              busy,
   output logic              tx_done
);

   localparam int               BAUD_W      = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] C_BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]        C_STOP_LAST = 3'(STOP_BITS - 1);

   state_e            r_state;
   logic              r_tx;
   logic              r_fifo_rd;
   logic              r_busy;
   logic              r_tx_done;
   logic [2:0]        r_bit_cnt;
   logic [DATA_W-1:0] r_shift;
   logic              r_parity;

   logic              w_baud_clr;
   logic              w_tick;
   logic [BAUD_W-1:0] w_baud_count;
   logic              w_frame_end;

   // Hold the bit timer at zero until the start bit begins
   assign w_baud_clr  = (r_state == ST_IDLE) || (r_state == ST_FETCH) ||
                        (r_state == ST_LOAD);
   assign w_frame_end = (r_state == ST_STOP) && (r_bit_cnt == C_STOP_LAST) &&
                        (w_baud_count == C_BAUD_LAST);

   uart_baud_tick #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clk   (clk),
      .rst   (rst),
      .clr   (w_baud_clr),
      .tick  (w_tick),
      .count (w_baud_count)
   );

   // Transmit sequencer with registered line, strobe and status outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= ST_IDLE;
         r_tx      <= 1'b1;
         r_fifo_rd <= 1'b0;
         r_busy    <= 1'b0;
         r_tx_done <= 1'b0;
         r_bit_cnt <= 3'd0;
         r_shift   <= '0;
         r_parity  <= 1'b0;
      end else begin
         r_fifo_rd <= 1'b0;
         r_tx_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_tx <= 1'b1;
               if (tx_en && !fifo_empty) begin
                  r_state   <= ST_FETCH;
                  r_fifo_rd <= 1'b1;
                  r_busy    <= 1'b1;
               end
            end
            ST_FETCH: begin
               r_tx    <= 1'b1;
               r_state <= ST_LOAD;
            end
            // FIFO output is valid now, one cycle after the pop
            ST_LOAD: begin
               r_tx     <= 1'b1;
               r_shift  <= fifo_data;
               r_parity <= even_parity(fifo_data);
               r_state  <= ST_START;
            end
            ST_START: begin
               r_tx <= 1'b0;
               if (w_tick) begin
                  r_state <= ST_DATA;
               end
            end
            ST_DATA: begin
               r_tx <= r_shift[0];
               if (w_tick) begin
                  r_shift   <= r_shift >> 1;
                  r_bit_cnt <= r_bit_cnt + 3'd1;
                  if (r_bit_cnt == 3'd7) begin
                     r_state <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                  end
               end
            end
            ST_PARITY: begin
               r_tx <= r_parity;
               if (w_tick) begin
                  r_state <= ST_STOP;
               end
            end
            // Bit counter is reused to count stop bits; it is 0 on entry
            ST_STOP: begin
               r_tx <= 1'b1;
               if (w_frame_end) begin
                  r_state   <= ST_IDLE;
                  r_busy    <= 1'b0;
                  r_tx_done <= 1'b1;
                  r_bit_cnt <= 3'd0;
               end else if (w_tick) begin
                  r_bit_cnt <= r_bit_cnt + 3'd1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_tx    <= 1'b1;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign tx      = r_tx;
   assign fifo_rd = r_fifo_rd;
   assign busy    = r_busy;
   assign tx_done = r_tx_done;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_uart_tx
//  Purpose  : Self-checking bench. Two transmitters (8N1 and 8E2, 4 clocks
//             per bit) each drain a behavioural FIFO; frames are compared
//             cycle by cycle with waveforms built from the frame rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx;

   localparam int CPB = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] tx_en = 2'b00;
   logic [1:0] fe;
   logic [1:0] rd;
   logic [1:0] txv;
   logic [1:0] busyv;
   logic [1:0] donev;
   logic [7:0] fdata [2] = '{8'h00, 8'h00};

   logic [7:0] mem [2][64];
   int         push_cnt [2] = '{0, 0};
   int         pop_cnt  [2] = '{0, 0};
   logic       underflow = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) dut0 (
      .clk(clk), .rst(rst), .tx_en(tx_en[0]), .fifo_empty(fe[0]),
      .fifo_data(fdata[0]), .fifo_rd(rd[0]), .tx(txv[0]), .busy(busyv[0]),
      .tx_done(donev[0]));

   fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(2)) dut1 (
      .clk(clk), .rst(rst), .tx_en(tx_en[1]), .fifo_empty(fe[1]),
      .fifo_data(fdata[1]), .fifo_rd(rd[1]), .tx(txv[1]), .busy(busyv[1]),
      .tx_done(donev[1]));

   // Behavioural FIFOs: registered read data, valid the cycle after a pop
   assign fe[0] = (push_cnt[0] == pop_cnt[0]);
   assign fe[1] = (push_cnt[1] == pop_cnt[1]);

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (rd[d]) begin
            if (push_cnt[d] == pop_cnt[d]) underflow <= 1'b1;
            fdata[d]   <= mem[d][pop_cnt[d] % 64];
            pop_cnt[d] <= pop_cnt[d] + 1;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic push(input int d, input logic [7:0] b);
      mem[d][push_cnt[d] % 64] = b;
      push_cnt[d] = push_cnt[d] + 1;
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Waits for the fetch strobe, then checks the whole frame cycle by cycle
   task automatic check_frame(input int d, input logic [7:0] b,
                              input int budget, input int drop_at);
      logic seq [12];
      int   n;
      int   stops;
      int   total;
      int   idx;
      logic got;
      logic exp_done;
      n = 0;
      seq[n] = 1'b0; n++;
      for (int i = 0; i < 8; i++) begin seq[n] = b[i]; n++; end
      if (d == 1) begin seq[n] = (($countones(b) % 2) == 1); n++; end
      stops = (d == 1) ? 2 : 1;
      for (int i = 0; i < stops; i++) begin seq[n] = 1'b1; n++; end
      total = n * CPB;

      got = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         @(negedge clk);
         got = rd[d];
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL fetch_wait dut%0d: fifo_rd=0 after %0d cycles, required 1", d, budget);
         return;
      end
      checks++;
      if (txv[d] !== 1'b1 || busyv[d] !== 1'b1) begin
         errors++;
         $display("FAIL fetch_state dut%0d: tx=%b busy=%b, required tx=1 busy=1", d, txv[d], busyv[d]);
      end
      @(negedge clk);
      checks++;
      if (rd[d] !== 1'b0 || txv[d] !== 1'b1) begin
         errors++;
         $display("FAIL load_state dut%0d: fifo_rd=%b tx=%b, required 0 and 1", d, rd[d], txv[d]);
      end
      @(negedge clk);
      checks++;
      if (txv[d] !== 1'b1) begin
         errors++;
         $display("FAIL pre_start dut%0d: tx=%b, required 1", d, txv[d]);
      end
      idx = 0;
      for (int j = 0; j < n; j++) begin
         for (int c = 0; c < CPB; c++) begin
            @(negedge clk);
            if (idx == drop_at) tx_en[d] = 1'b0;
            exp_done = (idx == total - 1);
            checks++;
            if (txv[d] !== seq[j]) begin
               errors++;
               $display("FAIL tx_bit dut%0d byte %h bit %0d cyc %0d: tx=%b, required %b",
                        d, b, j, c, txv[d], seq[j]);
            end
            checks++;
            if (donev[d] !== exp_done) begin
               errors++;
               $display("FAIL tx_done dut%0d cyc %0d: tx_done=%b, required %b", d, idx, donev[d], exp_done);
            end
            checks++;
            if (rd[d] !== 1'b0) begin
               errors++;
               $display("FAIL rd_in_frame dut%0d cyc %0d: fifo_rd=%b, required 0", d, idx, rd[d]);
            end
            if (idx != total - 1) begin
               checks++;
               if (busyv[d] !== 1'b1) begin
                  errors++;
                  $display("FAIL busy dut%0d cyc %0d: busy=%b, required 1", d, idx, busyv[d]);
               end
            end
            idx++;
         end
      end
   endtask

   task automatic check_quiet(input int d, input int n, input string name);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         checks++;
         if (rd[d] !== 1'b0 || txv[d] !== 1'b1 || busyv[d] !== 1'b0 || donev[d] !== 1'b0) begin
            errors++;
            $display("FAIL %s dut%0d cyc %0d: rd=%b tx=%b busy=%b done=%b, required 0 1 0 0",
                     name, d, i, rd[d], txv[d], busyv[d], donev[d]);
         end
      end
   endtask

   task automatic check_level(input int d, input int exp, input string name);
      checks++;
      if (push_cnt[d] - pop_cnt[d] != exp) begin
         errors++;
         $display("FAIL %s dut%0d: fifo holds %0d bytes, required %0d", name, d,
                  push_cnt[d] - pop_cnt[d], exp);
      end
   endtask

   task automatic test_reset();
      cyc(2);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (txv[d] !== 1'b1 || busyv[d] !== 1'b0 || rd[d] !== 1'b0 || donev[d] !== 1'b0) begin
            errors++;
            $display("FAIL reset_state dut%0d: tx=%b busy=%b rd=%b done=%b, required 1 0 0 0",
                     d, txv[d], busyv[d], rd[d], donev[d]);
         end
      end
      rst = 1'b1;
   endtask

   task automatic test_idle_hold();
      tx_en = 2'b11;
      check_quiet(0, 100, "idle_hold");
      check_quiet(1, 4, "idle_hold");
   endtask

   task automatic test_single();
      push(0, 8'hA5);
      check_frame(0, 8'hA5, 4, -1);
      check_quiet(0, 5, "single_after");
      check_level(0, 0, "single_level");
   endtask

   task automatic test_parity_stop();
      push(1, 8'h07);
      check_frame(1, 8'h07, 4, -1);
      check_quiet(1, 5, "parity_after");
   endtask

   task automatic test_back_to_back();
      push(0, 8'h55);
      push(0, 8'h0F);
      check_frame(0, 8'h55, 4, -1);
      check_frame(0, 8'h0F, 1, -1);
      check_quiet(0, 5, "b2b_after");
      check_level(0, 0, "b2b_level");
   endtask

   task automatic test_reset_mid();
      logic [7:0] b;
      logic       got;
      b = 8'($urandom);
      push(0, b);
      got = 1'b0;
      for (int i = 0; i < 4 && !got; i++) begin
         @(negedge clk);
         got = rd[0];
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL reset_mid_fetch: fifo_rd=0, required 1");
      end
      cyc(16);
      rst = 1'b0;
      #1;
      checks++;
      if (txv[0] !== 1'b1 || busyv[0] !== 1'b0 || rd[0] !== 1'b0 || donev[0] !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: tx=%b busy=%b rd=%b done=%b, required 1 0 0 0",
                  txv[0], busyv[0], rd[0], donev[0]);
      end
      @(negedge clk);
      rst = 1'b1;
      check_quiet(0, 50, "reset_mid_after");
      check_level(0, 0, "reset_mid_level");
   endtask

   task automatic test_enable_gating();
      logic [7:0] b [3];
      tx_en[0] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         b[i] = 8'($urandom);
         push(0, b[i]);
      end
      check_quiet(0, 30, "gated");
      tx_en[0] = 1'b1;
      check_frame(0, b[0], 4, 10);
      check_quiet(0, 30, "gated_after");
      check_level(0, 2, "gated_level");
      tx_en[0] = 1'b1;
      check_frame(0, b[1], 4, -1);
      check_frame(0, b[2], 1, -1);
      check_level(0, 0, "gated_drain");
   endtask

   task automatic test_random();
      logic [7:0] b0;
      logic [7:0] b1;
      for (int d = 0; d < 2; d++) begin
         for (int n = 0; n < 6; n++) begin
            cyc($urandom_range(0, 6));
            b0 = 8'($urandom);
            b1 = 8'($urandom);
            push(d, b0);
            if ($urandom_range(0, 1) == 1) begin
               push(d, b1);
               check_frame(d, b0, 4, -1);
               check_frame(d, b1, 1, -1);
            end else begin
               check_frame(d, b0, 4, -1);
            end
         end
         check_quiet(d, 5, "random_after");
         check_level(d, 0, "random_level");
      end
   endtask

   initial begin
      test_reset();
      test_idle_hold();
      test_single();
      test_parity_stop();
      test_back_to_back();
      test_reset_mid();
      test_enable_gating();
      test_random();
      checks++;
      if (underflow !== 1'b0) begin
         errors++;
         $display("FAIL underflow: pop while empty seen=%b, required 0", underflow);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
